// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM state codes and
// the port index used for grant / last_grant.
package mem_arb_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t ISSUE = 2'd1;
   localparam state_t WAIT  = 2'd2;
   localparam state_t DONE  = 2'd3;

   // Port indices: instruction fetch is m0, load/store is m1
   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports plus the memory-side bus.
// The slave modport is the arbiter's view; master is the surrounding
// SoC (processor ports and memory) view.
interface mem_arbiter_if #(
   parameter int DATA_WIDTH = 32
);
   localparam int MASK_WIDTH = DATA_WIDTH / 8;

   logic                  m0_valid;
   logic [31:0]           m0_addr;
   logic [DATA_WIDTH-1:0] m0_wdata;
   logic [MASK_WIDTH-1:0] m0_wmask;
   logic [DATA_WIDTH-1:0] m0_rdata;
   logic                  m0_done;

   logic                  m1_valid;
   logic [31:0]           m1_addr;
   logic [DATA_WIDTH-1:0] m1_wdata;
   logic [MASK_WIDTH-1:0] m1_wmask;
   logic [DATA_WIDTH-1:0] m1_rdata;
   logic                  m1_done;

   logic [31:0]           mem_addr;
   logic                  mem_rstrb;
   logic [MASK_WIDTH-1:0] mem_wmask;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  m0_valid, m0_addr, m0_wdata, m0_wmask,
      output m0_rdata, m0_done,
      input  m1_valid, m1_addr, m1_wdata, m1_wmask,
      output m1_rdata, m1_done,
      output mem_addr, mem_rstrb, mem_wmask, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output m0_valid, m0_addr, m0_wdata, m0_wmask,
      input  m0_rdata, m0_done,
      output m1_valid, m1_addr, m1_wdata, m1_wmask,
      input  m1_rdata, m1_done,
      input  mem_addr, mem_rstrb, mem_wmask, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way requester selector. With both ports requesting it either
// always picks m0 (fixed) or the port that did not win last time.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last_grant,
   input  logic       fixed,
   output logic       grant,
   output logic       any
);

   // Pick the winner among the currently requesting ports
   always_comb begin
      any   = |valid;
      grant = PORT_I;
      if (valid == 2'b11) begin
         grant = fixed ? PORT_I : ~last_grant;
      end else if (valid[1]) begin
         grant = PORT_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one registered-read word memory between the fetch port (m0) and
// the load/store port (m1). Every access walks IDLE -> ISSUE -> WAIT ->
// DONE, so a request sampled in IDLE sees its done pulse three cycles
// later and back-to-back accesses run at one per four cycles.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int FIXED_PRIORITY = 0,
   parameter int DATA_WIDTH     = 32
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);

   localparam int MASK_WIDTH = DATA_WIDTH / 8;

   state_t                state;
   logic                  grant;
   logic                  last_grant;
   logic                  is_read;

   logic                  pick_grant;
   logic                  pick_any;

   logic [31:0]           sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [MASK_WIDTH-1:0] sel_wmask;

   logic [31:0]           mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic [MASK_WIDTH-1:0] mem_wmask_q;
   logic                  mem_rstrb_q;

   logic [DATA_WIDTH-1:0] m0_rdata_q;
   logic [DATA_WIDTH-1:0] m1_rdata_q;
   logic                  m0_done_q;
   logic                  m1_done_q;

   rr_pick2 u_pick (
      .valid      ({bus.m1_valid, bus.m0_valid}),
      .last_grant (last_grant),
      .fixed      (FIXED_PRIORITY != 0),
      .grant      (pick_grant),
      .any        (pick_any)
   );

   // Route the request fields of whichever port the selector chose
   always_comb begin
      sel_addr  = bus.m0_addr;
      sel_wdata = bus.m0_wdata;
      sel_wmask = bus.m0_wmask;
      if (pick_grant == PORT_D) begin
         sel_addr  = bus.m1_addr;
         sel_wdata = bus.m1_wdata;
         sel_wmask = bus.m1_wmask;
      end
   end

   // Sequencer: fixed four-state walk, grant bookkeeping captured in IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= PORT_I;
         last_grant <= PORT_D;
         is_read    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  state      <= ISSUE;
                  grant      <= pick_grant;
                  last_grant <= pick_grant;
                  is_read    <= (sel_wmask == '0);
               end
            end
            ISSUE:   state <= WAIT;
            WAIT:    state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   // Memory side: load the bus in IDLE, strobe only during ISSUE
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wmask_q <= '0;
         mem_rstrb_q <= 1'b0;
      end else if (state == IDLE && pick_any) begin
         mem_addr_q  <= sel_addr;
         mem_wdata_q <= sel_wdata;
         mem_wmask_q <= sel_wmask;
         mem_rstrb_q <= (sel_wmask == '0);
      end else if (state == ISSUE) begin
         mem_wmask_q <= '0;
         mem_rstrb_q <= 1'b0;
      end
   end

   // Return side: capture read data in WAIT and pulse done through DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
         m0_done_q  <= 1'b0;
         m1_done_q  <= 1'b0;
      end else begin
         m0_done_q <= 1'b0;
         m1_done_q <= 1'b0;
         if (state == WAIT) begin
            if (grant == PORT_D) begin
               m1_done_q <= 1'b1;
               if (is_read) m1_rdata_q <= bus.mem_rdata;
            end else begin
               m0_done_q <= 1'b1;
               if (is_read) m0_rdata_q <= bus.mem_rdata;
            end
         end
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_wmask = mem_wmask_q;
   assign bus.mem_rstrb = mem_rstrb_q;
   assign bus.m0_rdata  = m0_rdata_q;
   assign bus.m1_rdata  = m1_rdata_q;
   assign bus.m0_done   = m0_done_q;
   assign bus.m1_done   = m1_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance fed
// with identical requests, each backed by its own registered-read memory.
module tb_mem_arbiter;

   typedef struct {
      logic        port;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] exp_rdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_mem;

   int          vectors = 0;
   int          miscompares = 0;

   logic [31:0] mem_rr [0:255];
   logic [31:0] mem_fp [0:255];
   logic [31:0] ref_mem [0:255];

   vec_t        vec_table [6];
   logic [31:0] exp_rd [2];

   logic        req_v [2];
   logic [31:0] req_addr [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_mask [2];

   mem_arbiter_if #(.DATA_WIDTH(32)) bus_rr ();
   mem_arbiter_if #(.DATA_WIDTH(32)) bus_fp ();

   mem_arbiter #(.FIXED_PRIORITY(0), .DATA_WIDTH(32)) dut_rr (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_rr)
   );

   mem_arbiter #(.FIXED_PRIORITY(1), .DATA_WIDTH(32)) dut_fp (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_fp)
   );

   assign bus_fp.m0_valid = bus_rr.m0_valid;
   assign bus_fp.m0_addr  = bus_rr.m0_addr;
   assign bus_fp.m0_wdata = bus_rr.m0_wdata;
   assign bus_fp.m0_wmask = bus_rr.m0_wmask;
   assign bus_fp.m1_valid = bus_rr.m1_valid;
   assign bus_fp.m1_addr  = bus_rr.m1_addr;
   assign bus_fp.m1_wdata = bus_rr.m1_wdata;
   assign bus_fp.m1_wmask = bus_rr.m1_wmask;

   always #5 clk = ~clk;

   // Power-on memory image: word 100 = 04030201, word 101 = 08070605, ...
   function automatic logic [31:0] init_word(input int k);
      logic [7:0] b;
      b = 8'(4 * (k - 100));
      return {b + 8'd4, b + 8'd3, b + 8'd2, b + 8'd1};
   endfunction

   // Two word memories with registered read and byte-masked write
   always @(posedge clk) begin
      if (load_mem) begin
         for (int k = 0; k < 256; k++) begin
            mem_rr[k] <= init_word(k);
            mem_fp[k] <= init_word(k);
         end
      end else begin
         if (bus_rr.mem_rstrb) bus_rr.mem_rdata <= mem_rr[bus_rr.mem_addr[9:2]];
         if (bus_fp.mem_rstrb) bus_fp.mem_rdata <= mem_fp[bus_fp.mem_addr[9:2]];
         for (int b = 0; b < 4; b++) begin
            if (bus_rr.mem_wmask[b])
               mem_rr[bus_rr.mem_addr[9:2]][8*b +: 8] <= bus_rr.mem_wdata[8*b +: 8];
            if (bus_fp.mem_wmask[b])
               mem_fp[bus_fp.mem_addr[9:2]][8*b +: 8] <= bus_fp.mem_wdata[8*b +: 8];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input logic p, input logic v, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] m);
      if (p == 1'b0) begin
         bus_rr.m0_valid = v;
         bus_rr.m0_addr  = a;
         bus_rr.m0_wdata = d;
         bus_rr.m0_wmask = m;
      end else begin
         bus_rr.m1_valid = v;
         bus_rr.m1_addr  = a;
         bus_rr.m1_wdata = d;
         bus_rr.m1_wmask = m;
      end
   endtask

   task automatic do_reset();
      apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
      reset    = 1'b1;
      load_mem = 1'b1;
      tick();
      tick();
      reset    = 1'b0;
      load_mem = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check_output({tag, " mem_addr"},  bus_rr.mem_addr, 32'd0);
      check_output({tag, " mem_wdata"}, bus_rr.mem_wdata, 32'd0);
      check_output({tag, " mem_wmask"}, 32'(bus_rr.mem_wmask), 32'd0);
      check_output({tag, " mem_rstrb"}, 32'(bus_rr.mem_rstrb), 32'd0);
      check_output({tag, " m0_rdata"},  bus_rr.m0_rdata, 32'd0);
      check_output({tag, " m1_rdata"},  bus_rr.m1_rdata, 32'd0);
      check_output({tag, " m0_done"},   32'(bus_rr.m0_done), 32'd0);
      check_output({tag, " m1_done"},   32'(bus_rr.m1_done), 32'd0);
   endtask

   function automatic logic [31:0] rr_done(input logic p);
      return p ? 32'(bus_rr.m1_done) : 32'(bus_rr.m0_done);
   endfunction

   function automatic logic [31:0] rr_rdata(input logic p);
      return p ? bus_rr.m1_rdata : bus_rr.m0_rdata;
   endfunction

   task automatic new_request(input logic p);
      req_v[p]     = 1'b1;
      req_addr[p]  = 32'd400 + 32'(4 * $urandom_range(7)) + 32'($urandom_range(3));
      req_wdata[p] = $urandom;
      req_mask[p]  = ($urandom_range(1) == 0) ? 4'b0000 : 4'($urandom_range(15, 1));
      apply_stimulus(p, 1'b1, req_addr[p], req_wdata[p], req_mask[p]);
   endtask

   initial begin
      logic p;
      logic last_p;
      int   sample_at;
      int   done_at;
      logic done_port;
      logic [7:0] w;

      vec_table[0] = '{1'b0, 32'd400, 32'h0,        4'b0000, 32'h04030201};
      vec_table[1] = '{1'b1, 32'd404, 32'h0,        4'b0000, 32'h08070605};
      vec_table[2] = '{1'b1, 32'd408, 32'hAABBCCDD, 4'b0011, 32'h08070605};
      vec_table[3] = '{1'b1, 32'd408, 32'h0,        4'b0000, 32'h0C0BCCDD};
      vec_table[4] = '{1'b0, 32'd412, 32'h11223344, 4'b1111, 32'h04030201};
      vec_table[5] = '{1'b0, 32'd412, 32'h0,        4'b0000, 32'h11223344};

      reset    = 1'b1;
      load_mem = 1'b1;
      do_reset();
      check_reset_state("reset");

      // Single-port accesses, one vector per access
      exp_rd[0] = 32'd0;
      exp_rd[1] = 32'd0;
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(vec_table[i].port, 1'b1, vec_table[i].addr,
                        vec_table[i].wdata, vec_table[i].wmask);
         check_output("idle rstrb", 32'(bus_rr.mem_rstrb), 32'd0);
         tick();
         check_output("issue rstrb", 32'(bus_rr.mem_rstrb),
                      32'(vec_table[i].wmask == 4'b0000));
         check_output("issue wmask", 32'(bus_rr.mem_wmask), 32'(vec_table[i].wmask));
         check_output("issue addr", bus_rr.mem_addr, vec_table[i].addr);
         check_output("issue wdata", bus_rr.mem_wdata, vec_table[i].wdata);
         tick();
         check_output("wait rstrb", 32'(bus_rr.mem_rstrb), 32'd0);
         check_output("wait wmask", 32'(bus_rr.mem_wmask), 32'd0);
         check_output("wait addr", bus_rr.mem_addr, vec_table[i].addr);
         check_output("wait done", rr_done(vec_table[i].port), 32'd0);
         tick();
         check_output("done own", rr_done(vec_table[i].port), 32'd1);
         check_output("done other", rr_done(~vec_table[i].port), 32'd0);
         check_output("rdata own", rr_rdata(vec_table[i].port), vec_table[i].exp_rdata);
         check_output("rdata other", rr_rdata(~vec_table[i].port), exp_rd[~vec_table[i].port]);
         apply_stimulus(vec_table[i].port, 1'b0, vec_table[i].addr,
                        vec_table[i].wdata, vec_table[i].wmask);
         exp_rd[vec_table[i].port] = vec_table[i].exp_rdata;
         tick();
         check_output("after done", rr_done(vec_table[i].port), 32'd0);
      end

      // Reset during WAIT of an m0 read; m1 joins so the restart is a tie
      apply_stimulus(1'b0, 1'b1, 32'd400, 32'd0, 4'b0000);
      tick();
      tick();
      reset = 1'b1;
      apply_stimulus(1'b1, 1'b1, 32'd404, 32'd0, 4'b0000);
      tick();
      check_reset_state("midreset");
      reset = 1'b0;
      tick();
      check_output("midreset r1 m0_done", 32'(bus_rr.m0_done), 32'd0);
      tick();
      check_output("midreset r2 m0_done", 32'(bus_rr.m0_done), 32'd0);
      tick();
      check_output("midreset m0 wins", 32'(bus_rr.m0_done), 32'd1);
      check_output("midreset m1 idle", 32'(bus_rr.m1_done), 32'd0);
      check_output("midreset m0_rdata", bus_rr.m0_rdata, 32'h04030201);
      apply_stimulus(1'b0, 1'b0, 32'd400, 32'd0, 4'b0000);
      for (int k = 0; k < 4; k++) tick();
      check_output("midreset m1 served", 32'(bus_rr.m1_done), 32'd1);
      check_output("midreset m1_rdata", bus_rr.m1_rdata, 32'h08070605);
      apply_stimulus(1'b1, 1'b0, 32'd404, 32'd0, 4'b0000);
      tick();

      // m1 drops valid during ISSUE: one completion, no second access
      apply_stimulus(1'b1, 1'b1, 32'd404, 32'd0, 4'b0000);
      tick();
      apply_stimulus(1'b1, 1'b0, 32'd404, 32'd0, 4'b0000);
      check_output("drop issue rstrb", 32'(bus_rr.mem_rstrb), 32'd1);
      tick();
      tick();
      check_output("drop m1_done", 32'(bus_rr.m1_done), 32'd1);
      for (int k = 0; k < 6; k++) begin
         tick();
         check_output("drop no redone", 32'(bus_rr.m1_done), 32'd0);
         check_output("drop no reissue", 32'(bus_rr.mem_rstrb), 32'd0);
      end

      // Both ports held: round-robin alternates, fixed priority keeps m0
      do_reset();
      apply_stimulus(1'b0, 1'b1, 32'd400, 32'd0, 4'b0000);
      apply_stimulus(1'b1, 1'b1, 32'd404, 32'd0, 4'b0000);
      for (int g = 0; g < 4; g++) begin
         tick();
         check_output("both r1 done", rr_done(1'b0) | rr_done(1'b1), 32'd0);
         tick();
         check_output("both r2 done", rr_done(1'b0) | rr_done(1'b1), 32'd0);
         tick();
         check_output("rr m0_done", 32'(bus_rr.m0_done), 32'((g % 2) == 0));
         check_output("rr m1_done", 32'(bus_rr.m1_done), 32'((g % 2) == 1));
         check_output("rr rdata", rr_rdata(1'(g % 2)),
                      ((g % 2) == 0) ? 32'h04030201 : 32'h08070605);
         check_output("fp m0_done", 32'(bus_fp.m0_done), 32'd1);
         check_output("fp m1_done", 32'(bus_fp.m1_done), 32'd0);
         check_output("fp m1_rdata", bus_fp.m1_rdata, 32'd0);
         tick();
      end

      // Random traffic against a transaction-schedule model
      do_reset();
      for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
      exp_rd[0] = 32'd0;
      exp_rd[1] = 32'd0;
      req_v[0]  = 1'b0;
      req_v[1]  = 1'b0;
      last_p    = 1'b1;
      sample_at = 0;
      done_at   = -10;
      done_port = 1'b0;
      for (int c = 0; c < 400; c++) begin
         check_output("rand m0_done", 32'(bus_rr.m0_done),
                      32'(c == done_at && done_port == 1'b0));
         check_output("rand m1_done", 32'(bus_rr.m1_done),
                      32'(c == done_at && done_port == 1'b1));
         if (c == done_at) begin
            check_output("rand m0_rdata", bus_rr.m0_rdata, exp_rd[0]);
            check_output("rand m1_rdata", bus_rr.m1_rdata, exp_rd[1]);
            if ($urandom_range(1) == 0) begin
               req_v[done_port] = 1'b0;
               apply_stimulus(done_port, 1'b0, req_addr[done_port],
                              req_wdata[done_port], req_mask[done_port]);
            end else begin
               new_request(done_port);
            end
         end
         for (int q = 0; q < 2; q++) begin
            if (!req_v[q] && $urandom_range(2) == 0) new_request(1'(q));
         end
         if (c == sample_at) begin
            if (req_v[0] || req_v[1]) begin
               if (req_v[0] && req_v[1]) p = (last_p == 1'b0) ? 1'b1 : 1'b0;
               else p = req_v[1];
               last_p = p;
               w = req_addr[p][9:2];
               if (req_mask[p] == 4'b0000) begin
                  exp_rd[p] = ref_mem[w];
               end else begin
                  for (int b = 0; b < 4; b++)
                     if (req_mask[p][b]) ref_mem[w][8*b +: 8] = req_wdata[p][8*b +: 8];
               end
               done_port = p;
               done_at   = c + 3;
               sample_at = c + 4;
            end else begin
               sample_at = c + 1;
            end
         end
         tick();
      end
      apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter sharing the single-port 32-bit word memory (registered read, `mem_rstrb` strobe, `mem_wmask` byte writes) between the instruction-fetch port (m0) and the load/store port (m1).
- Sequences each access through a fixed 4-state FSM.
- Selects between simultaneous requesters by round-robin or fixed priority.
- Returns registered read data with a one-cycle done pulse.
- Sits between the processor and the memory in the SoC top.

Parameters:
- FIXED_PRIORITY, 0, 1 = m0 always wins ties; 0 = round-robin.
- DATA_WIDTH, 32, word width; the byte mask width is DATA_WIDTH/8.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- m0_valid  in  1  fetch request; held high until m0_done is seen.
- m0_addr  in  32  byte address; bits [1:0] are passed through untouched.
- m0_wdata  in  32  write data.
- m0_wmask  in  4  byte write enables; 4'b0000 = read.
- m0_rdata  out  32  registered read data.
- m0_done  out  1  one-cycle completion pulse.
- m1_valid, m1_addr, m1_wdata, m1_wmask, m1_rdata, m1_done: same as the m0 ports, for the load/store port.
- mem_addr  out  32  address to memory.
- mem_rstrb  out  1  read strobe.
- mem_wmask  out  4  write mask.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read data; valid the cycle after mem_rstrb.

Behaviour:
- Reset: the following registers go to 0:
  - state = IDLE
  - all mem_* outputs
  - m0_rdata, m1_rdata, m0_done, m1_done
  - last_grant = 1, so m0 wins the first tie
- Reset is synchronous and overrides all other logic.
- FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. No stalls; every access takes exactly 4 states.
- IDLE:
  - Sample m0_valid and m1_valid.
  - Only one port valid: grant it.
  - Both valid, FIXED_PRIORITY=1: grant m0.
  - Both valid, FIXED_PRIORITY=0: grant the port != last_grant.
  - On the IDLE edge, register: grant, last_grant <= grant, mem_addr/mem_wdata/mem_wmask from the granted port, mem_rstrb <= (granted wmask == 0).
  - No valid: stay in IDLE, all mem_* strobes at 0.
- ISSUE: mem_rstrb or mem_wmask is asserted for exactly this one cycle. Both are cleared on exit.
- WAIT:
  - mem_addr and mem_wdata stay stable.
  - If the access is a read, latch mem_rdata into the granted port's rdata.
  - The other port's rdata is unchanged.
- DONE: the granted port's done is 1 for this one cycle; the other port's done stays 0.
- Done timing: valid sampled in IDLE at cycle T -> done high in cycle T+3.
- Back-to-back throughput: one access per 4 cycles.
- Writes: the rdata register is not modified; done still pulses.
- The requester must drop valid (or present its next request) on the edge ending its done cycle. IDLE resamples in the following cycle, so no request is double-served.
- Valid dropped mid-transaction is ignored; the access completes and done pulses.
- Request fields are captured only in IDLE. Changes while the port is not in IDLE have no effect.
- m0_done and m1_done are never high simultaneously.
- Reset mid-transaction:
  - Immediate return to IDLE; no done pulse; the request is dropped.
  - A write already strobed in ISSUE has taken effect in memory.
- No combinational path from any input to any output.

Decomposition:
- Shared package `mem_arb_pkg`:
  - state encoding localparams: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3
  - port index localparams: PORT_I=1'b0, PORT_D=1'b1
- Optional sub-module `rr_pick2`: combinational 2-way round-robin/fixed selector.
  - Inputs: valid[1:0], last_grant, fixed.
  - Outputs: grant, any.
- Everything else lives in mem_arbiter.

Test Plan:
- Reset, then m0 read at addr 400 with memory word 100 = 32'hFF0F0E0D... wait, use word 100 = 32'h04030201: m0_done high 3 cycles after the valid sample, m0_rdata = 32'h04030201, mem_rstrb high exactly one cycle, m1_rdata stays 0.
- m0 and m1 reads both asserted continuously (m0 addr 400, m1 addr 404 = 32'h08070605), round-robin: grants alternate m0, m1, m0, m1; done every 4 cycles; m1_rdata = 32'h08070605. With FIXED_PRIORITY=1 and both held: m0 served on every grant.
- m1 write, addr 408, wmask 4'b0011, wdata 32'hAABBCCDD: mem_wmask = 4'b0011 and mem_rstrb = 0 for one cycle; then m1 read of 408 returns 32'h0C0BCCDD; m1_rdata unchanged after the write's done.
- Reset asserted in the WAIT cycle of an m0 read: no m0_done; all outputs 0 the next cycle; the next m0 request is served normally and wins the tie against m1.
- m1_valid dropped during ISSUE: transaction still completes, m1_done pulses once, and no second access is issued.
